// File: rtl/uart_rx_fifo.sv
// Purpose: receive byte FIFO between the UART AXI-stream output and the CSR data read path.
// Latency: a byte pushed at edge N is on rd_data_o (first-word fall-through) in cycle N+1.
// Backpressure: none; tready is 1 outside reset, bytes arriving while full are dropped and flagged.
module uart_rx_fifo #(
  parameter int DEPTH     = 16,
  parameter int WIDTH     = 8,
  parameter int THRESHOLD = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [WIDTH-1:0]           s_axis_tdata,
  input  logic                       s_axis_tvalid,
  output logic                       s_axis_tready,
  output logic [WIDTH-1:0]           rd_data_o,
  output logic                       not_empty_o,
  input  logic                       rd_strobe_i,
  output logic [$clog2(DEPTH+1)-1:0] level_o,
  output logic                       overrun_o,
  input  logic                       clr_overrun_i,
  input  logic                       flush_i,
  output logic                       irq_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int LW = $clog2(DEPTH + 1);
  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
  localparam logic [LW-1:0] THRESH_L = LW'(THRESHOLD);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [LW-1:0]    level;
  logic [LW-1:0]    level_nxt;
  logic             overrun;
  logic             irq;

  logic full;
  logic push_req;
  logic pop;
  logic push;
  logic drop;
  logic irq_nxt;

  // The receiver is only held off while reset is asserted.
  assign s_axis_tready = ~rst_i;

  assign full     = (level == DEPTH_L);
  assign push_req = s_axis_tvalid & s_axis_tready;
  assign pop      = rd_strobe_i & not_empty_o;
  // A full FIFO still takes a byte when the head leaves in the same cycle.
  assign push     = push_req & (~full | pop);
  assign drop     = push_req & full & ~pop;

  // Next fill level: moves only when exactly one of push/pop happens.
  always_comb begin
    level_nxt = level;
    case ({push, pop})
      2'b10:   level_nxt = level + LW'(1);
      2'b01:   level_nxt = level - LW'(1);
      default: level_nxt = level;
    endcase
  end

  // Threshold strobe fires only on the upward crossing; flush never crosses upward.
  always_comb begin
    irq_nxt = 1'b0;
    if (!flush_i) begin
      irq_nxt = (level < THRESH_L) && (level_nxt >= THRESH_L);
    end
  end

  // Pointer and level registers; flush empties the FIFO but leaves overrun alone.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      level <= level_nxt;
    end
  end

  // Storage write; contents need no reset because level gates their visibility.
  always_ff @(posedge clk_i) begin
    if (!rst_i && !flush_i && push) begin
      mem[wr_ptr[AW-1:0]] <= s_axis_tdata;
    end
  end

  // Sticky overrun: a new drop wins over a same-cycle clear.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      overrun <= 1'b0;
    end else if (drop && !flush_i) begin
      overrun <= 1'b1;
    end else if (clr_overrun_i) begin
      overrun <= 1'b0;
    end
  end

  // Registered one-cycle threshold strobe.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      irq <= 1'b0;
    end else begin
      irq <= irq_nxt;
    end
  end

  assign level_o     = level;
  assign not_empty_o = (level != '0);
  assign overrun_o   = overrun;
  assign irq_o       = irq;
  // Head is forced to zero while empty so the output is clean after reset.
  assign rd_data_o   = not_empty_o ? mem[rd_ptr[AW-1:0]] : '0;

  // Pointer distance must always agree with the level counter.
  ptr_level_consistent : assert property (
    @(posedge clk_i) disable iff (rst_i)
    (PW'(wr_ptr - rd_ptr) == PW'(level))
  );

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Receive-side byte FIFO between the UART receiver's AXI-stream output and the CSR UART_DATA read path. The UART core has a single-byte holding register; this block buffers incoming bytes so CPU interrupt latency does not drop characters. It exposes a first-word-fall-through head byte to the CSR block, a fill level, a sticky overrun flag, and a threshold interrupt strobe for the interrupt controller.

Parameters:
DEPTH, 16, number of byte entries; power of two, >= 2
WIDTH, 8, data width in bits
THRESHOLD, 8, fill level that raises the irq_o strobe; 1..DEPTH

Ports:
clk_i  input  1  system clock
rst_i  input  1  synchronous reset, active-high
s_axis_tdata  input  WIDTH  byte from the UART receiver
s_axis_tvalid  input  1  byte valid
s_axis_tready  output  1  always 1 out of reset (block never back-pressures)
rd_data_o  output  WIDTH  head entry; valid only while not_empty_o=1
not_empty_o  output  1  FIFO holds at least one entry
rd_strobe_i  input  1  pop head (CSR UART_DATA read strobe)
level_o  output  $clog2(DEPTH+1)  current entry count, 0..DEPTH
overrun_o  output  1  sticky: a byte was dropped because the FIFO was full
clr_overrun_i  input  1  clear overrun_o
flush_i  input  1  discard all contents
irq_o  output  1  one-cycle strobe on a rising crossing of THRESHOLD

Behaviour:
- Storage: DEPTH x WIDTH register array. Read and write pointers are $clog2(DEPTH)+1 bits wide; the MSB distinguishes full from empty. Pointers wrap modulo 2*DEPTH.
- Reset (rst_i=1 at a clock edge): pointers=0, level_o=0, not_empty_o=0, overrun_o=0, irq_o=0, rd_data_o=0. s_axis_tready=0 during reset and 1 otherwise. Reset mid-operation discards contents immediately.
- push = s_axis_tvalid & s_axis_tready; pop = rd_strobe_i & not_empty_o. rd_strobe_i while empty is ignored.
- Push accepted when not full, or when full and pop occurs in the same cycle. The write lands at wr_ptr and wr_ptr increments.
- Push while full without a simultaneous pop: the byte is dropped and overrun_o is set on the next edge. The pointers do not change.
- Pop: rd_ptr increments. The next head appears on rd_data_o in the following cycle.
- Simultaneous push and pop: level unchanged, both pointers advance. If empty, only the push takes effect.
- Latency: a byte pushed at edge N gives not_empty_o=1 and rd_data_o=that byte after edge N (visible cycle N+1). rd_data_o is driven combinationally from mem[rd_ptr]. When empty, its value is don't-care; the bench must not check it.
- level_o is a registered counter: +1 on an effective push only, -1 on a pop only, unchanged for both or neither. not_empty_o = (level_o != 0).
- flush_i has priority over push and pop, below rst_i. It sets pointers=0 and level_o=0, discards any same-cycle push, and generates no irq_o. overrun_o is unaffected.
- overrun_o: set has priority over clr_overrun_i in the same cycle, so no event is lost.
- irq_o: registered. It is 1 for exactly one cycle after the edge where level goes from < THRESHOLD to >= THRESHOLD. There is no repeat while level stays >= THRESHOLD. It re-arms once level falls below THRESHOLD.
- Full = (level_o == DEPTH). Overrun accounting uses full, not pointer compare mismatch.

Test Plan:
- Reset, then push 0x41,0x42,0x43 on consecutive cycles -> level_o=3 and rd_data_o=0x41. Three pops return 0x41,0x42,0x43 in order; not_empty_o=0 after the third.
- DEPTH=16: push 17 bytes 0x00..0x10 with no pops -> level_o=16 and overrun_o=1. The pop sequence reads 0x00..0x0F (0x10 is lost). clr_overrun_i -> overrun_o=0.
- Full FIFO, same-cycle push 0xAA and pop -> level_o stays 16, overrun_o stays 0, 0xAA is read last. Run 40 push/pop pairs to exercise pointer wrap-around with data intact.
- THRESHOLD=8: push 8 bytes -> irq_o high exactly one cycle, after the 8th push. A 9th push gives no strobe. Pop to 7 then push to 8 -> second one-cycle strobe.
- Push 5 bytes, then flush_i together with a push of 0x55 -> level_o=0, not_empty_o=0, no irq_o. The next push of 0x66 reads back 0x66.
- Empty FIFO with rd_strobe_i held for 3 cycles -> level_o stays 0 with no underflow. An assert of rst_i with 4 entries queued -> level_o=0, overrun_o=0 on the next cycle.
